// File: rtl/io_pkg.sv
// MMIO I/O controller shared definitions: region nibble, register offsets,
// and the decoded-access record used by the top level.
// Latency: n/a (constants and a pure combinational helper only).
// Backpressure: n/a.
package io_pkg;

  localparam logic [3:0] REGION      = 4'h8;

  localparam logic [7:0] OFF_TX_STAT = 8'h00;
  localparam logic [7:0] OFF_RX_STAT = 8'h04;
  localparam logic [7:0] OFF_TX_DATA = 8'h08;
  localparam logic [7:0] OFF_RX_DATA = 8'h0C;
  localparam logic [7:0] OFF_CYC     = 8'h10;
  localparam logic [7:0] OFF_INS     = 8'h14;
  localparam logic [7:0] OFF_CNT_CLR = 8'h18;
  localparam logic [7:0] OFF_STATUS  = 8'h1C;

  // One decoded CPU access for the current cycle
  typedef struct packed {
    logic       wr;
    logic       rd;
    logic [7:0] off;
  } io_acc_t;

  // A store wins over a load; nothing happens off-region or while stalled.
  function automatic io_acc_t decode_acc(input logic [31:0] addr,
                                         input logic we, input logic re,
                                         input logic stall);
    io_acc_t a;
    logic    ok;
    ok    = (addr[31:28] == REGION) && !stall;
    a.wr  = ok && we;
    a.rd  = ok && re && !we;
    a.off = addr[7:0];
    return a;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, no bypass: a pushed entry is visible at the head one cycle later.
// Latency: 1 cycle push-to-head. Full/empty/count come straight from registered pointers.
// Backpressure: push ignored when full, pop ignored when empty.
// Ports: clk, rst_n (sync, active-low) | push, push_data | pop, pop_data (head) |
//        full, empty, count (entries held, log2(DEPTH)+1 bits).
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int         AW  = $clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB distinguishes full from empty when the index bits match
  assign empty    = (wptr == rptr);
  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count    = wptr - rptr;
  assign pop_data = mem[rptr[AW-1:0]];

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + ONE;
      if (do_pop)  rptr <= rptr + ONE;
    end
  end

  // Storage is not reset; stale entries are unreachable once pointers clear
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/mmio_io_ctrl.sv
// Memory-mapped UART/counter block on the CPU data port: TX/RX FIFOs, cycle and
// retired-instruction counters, sticky overflow flags. Load data is registered (1 cycle).
// Backpressure: tx_valid/tx_ready and rx_valid/rx_ready handshakes; stall freezes CPU-side effects.
// Ports: clk, rst_n (sync, active-low) | stall, addr, wdata, we, re, retire from the pipeline |
//        rdata to stage Z | tx_data/tx_valid/tx_ready and rx_data/rx_valid/rx_ready to the UART.
module mmio_io_ctrl
  import io_pkg::*;
#(
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8,
  parameter int DATA_W   = 8,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  input  logic              we,
  input  logic              re,
  input  logic              retire,
  output logic [31:0]       rdata,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready
);

  localparam int TX_CW = $clog2(TX_DEPTH) + 1;
  localparam int RX_CW = $clog2(RX_DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  io_acc_t           acc;
  logic              tx_push_req;
  logic              tx_full;
  logic              tx_empty;
  logic [TX_CW-1:0]  tx_cnt;
  logic              rx_pop_req;
  logic              rx_push;
  logic              rx_full;
  logic              rx_empty;
  logic [RX_CW-1:0]  rx_cnt;
  logic [DATA_W-1:0] rx_head;
  logic              cnt_clr;
  logic              flag_clr;
  logic [CNT_W-1:0]  cyc_cnt;
  logic [CNT_W-1:0]  ins_cnt;
  logic              tx_ovf;
  logic              rx_ovf;
  logic [31:0]       rd_mux;

  // Address bits above the offset inside the region and high store-data bits are don't-care
  logic unused_bits;
  assign unused_bits = ^{addr[27:8], wdata[31:DATA_W]};

  assign acc         = decode_acc(addr, we, re, stall);
  assign tx_push_req = acc.wr && (acc.off == OFF_TX_DATA);
  assign rx_pop_req  = acc.rd && (acc.off == OFF_RX_DATA);
  assign cnt_clr     = acc.wr && (acc.off == OFF_CNT_CLR);
  assign flag_clr    = acc.wr && (acc.off == OFF_STATUS);

  assign tx_valid    = !tx_empty;
  // Held low during reset so the UART cannot hand over a byte that would be discarded
  assign rx_ready    = rst_n && !rx_full;
  assign rx_push     = rx_valid && rx_ready;

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (tx_push_req),
    .push_data (wdata[DATA_W-1:0]),
    .pop       (tx_valid && tx_ready),
    .pop_data  (tx_data),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_cnt)
  );

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rx_push),
    .push_data (rx_data),
    .pop       (rx_pop_req),
    .pop_data  (rx_head),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_cnt)
  );

  always_comb begin
    rd_mux = '0;
    case (acc.off)
      OFF_TX_STAT: rd_mux = {31'b0, !tx_full};
      OFF_RX_STAT: rd_mux = {31'b0, !rx_empty};
      OFF_RX_DATA: rd_mux = rx_empty ? 32'b0 : 32'(rx_head);
      OFF_CYC:     rd_mux = 32'(cyc_cnt);
      OFF_INS:     rd_mux = 32'(ins_cnt);
      OFF_STATUS:  rd_mux = {8'b0, 8'(tx_cnt), 8'(rx_cnt), 6'b0, rx_ovf, tx_ovf};
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata   <= '0;
      cyc_cnt <= '0;
      ins_cnt <= '0;
      tx_ovf  <= 1'b0;
      rx_ovf  <= 1'b0;
    end else begin
      if (acc.rd) rdata <= rd_mux;

      // Clear beats a coincident increment
      if (cnt_clr) begin
        cyc_cnt <= '0;
        ins_cnt <= '0;
      end else begin
        cyc_cnt <= cyc_cnt + CNT_ONE;
        if (retire && !stall) ins_cnt <= ins_cnt + CNT_ONE;
      end

      if (flag_clr) begin
        tx_ovf <= 1'b0;
        rx_ovf <= 1'b0;
      end else begin
        if (tx_push_req && tx_full)  tx_ovf <= 1'b1;
        if (rx_pop_req  && rx_empty) rx_ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Self-checking bench for mmio_io_ctrl: directed scenarios plus randomized traffic
// checked by a queue-based reference model and an independent output monitor.
// Counters are built 8 bits wide so wrap-around is reachable in a short run.
module tb_mmio_io_ctrl;

  localparam int TXD  = 8;
  localparam int RXD  = 8;
  localparam int CW   = 8;
  localparam int CMOD = 1 << CW;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        re;
  logic        retire;
  logic [31:0] rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;

  mmio_io_ctrl #(.TX_DEPTH(TXD), .RX_DEPTH(RXD), .DATA_W(8), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .stall    (stall),
    .addr     (addr),
    .wdata    (wdata),
    .we       (we),
    .re       (re),
    .retire   (retire),
    .rdata    (rdata),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit mon_on = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  mtx[$];
  logic [7:0]  mrx[$];
  logic [31:0] exp_rd[$];
  logic [7:0]  exp_tx[$];
  int          m_cyc;
  int          m_ins;
  logic        m_tovf;
  logic        m_rovf;

  always @(posedge clk) begin : model
    logic        hit, wr, rd, clr;
    logic [7:0]  o;
    int          txn, rxn;
    logic [31:0] rv;
    if (!rst_n) begin
      mtx.delete(); mrx.delete(); exp_rd.delete(); exp_tx.delete();
      m_cyc = 0; m_ins = 0; m_tovf = 1'b0; m_rovf = 1'b0;
    end else begin
      hit = (addr[31:28] == 4'h8) && !stall;
      wr  = hit && we;
      rd  = hit && re && !we;
      o   = addr[7:0];
      txn = mtx.size();
      rxn = mrx.size();
      if (rd) begin
        case (o)
          8'h00:   rv = (txn < TXD) ? 32'd1 : 32'd0;
          8'h04:   rv = (rxn > 0) ? 32'd1 : 32'd0;
          8'h0C:   rv = (rxn > 0) ? 32'(mrx[0]) : 32'd0;
          8'h10:   rv = 32'(m_cyc);
          8'h14:   rv = 32'(m_ins);
          8'h1C:   rv = (32'(txn) << 16) | (32'(rxn) << 8) | {30'b0, m_rovf, m_tovf};
          default: rv = 32'd0;
        endcase
        exp_rd.push_back(rv);
      end
      if (txn > 0 && tx_ready) void'(mtx.pop_front());
      if (wr && o == 8'h08) begin
        if (txn < TXD) begin
          mtx.push_back(wdata[7:0]);
          exp_tx.push_back(wdata[7:0]);
        end else m_tovf = 1'b1;
      end
      if (rd && o == 8'h0C) begin
        if (rxn > 0) void'(mrx.pop_front());
        else m_rovf = 1'b1;
      end
      if (rx_valid && rxn < RXD) mrx.push_back(rx_data);
      if (wr && o == 8'h1C) begin
        m_tovf = 1'b0;
        m_rovf = 1'b0;
      end
      clr   = wr && o == 8'h18;
      m_cyc = clr ? 0 : (m_cyc + 1) % CMOD;
      m_ins = clr ? 0 : ((retire && !stall) ? (m_ins + 1) % CMOD : m_ins);
    end
  end

  // ---------------- monitor ----------------
  logic [31:0] last_rd = 32'd0;

  always @(negedge clk) begin
    if (mon_on) begin
      if (!rst_n) begin
        last_rd = 32'd0;
        chk("rx_ready_in_reset", {31'b0, rx_ready}, 32'd0);
      end else begin
        if (exp_rd.size() > 0) begin
          last_rd = exp_rd.pop_front();
          chk("rdata", rdata, last_rd);
        end else begin
          chk("rdata_hold", rdata, last_rd);
        end
        chk("tx_valid", {31'b0, tx_valid}, {31'b0, mtx.size() != 0});
        chk("rx_ready", {31'b0, rx_ready}, {31'b0, mrx.size() < RXD});
        if (tx_valid && tx_ready) begin
          if (exp_tx.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL tx_extra: got byte 0x%02h expected no byte at %0t", tx_data, $time);
          end else begin
            chk("tx_data", {24'b0, tx_data}, {24'b0, exp_tx.pop_front()});
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic w, input logic r, input logic [7:0] off, input logic [31:0] d);
    we    = w;
    re    = r;
    addr  = {4'h8, 20'h0, off};
    wdata = d;
    @(posedge clk);
    #1;
    we = 1'b0;
    re = 1'b0;
  endtask

  task automatic rd(input logic [7:0] off);
    step(1'b0, 1'b1, off, 32'h0);
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] d);
    step(1'b1, 1'b0, off, d);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 8'h00, 32'h0);
  endtask

  logic [7:0] offs [10] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h20, 8'h03};

  initial begin
    rst_n = 1'b0; stall = 1'b0; addr = '0; wdata = '0; we = 1'b0; re = 1'b0;
    retire = 1'b0; tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_tx_valid", {31'b0, tx_valid}, 32'd0);
    chk("reset_rx_ready", {31'b0, rx_ready}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("post_reset_rx_ready", {31'b0, rx_ready}, 32'd1);
    mon_on = 1;

    // Status after reset, cycle counter five cycles in
    rd(8'h00); chk("tx_not_full", rdata, 32'd1);
    rd(8'h04); chk("rx_not_empty", rdata, 32'd0);
    idle(); idle(); idle();
    rd(8'h10); chk("cyc_at_5", rdata, 32'd5);

    // Two stores drained in order
    tx_ready = 1'b0;
    wr(8'h08, 32'h0000_0041);
    wr(8'h08, 32'hFFFF_FF42);
    tx_ready = 1'b1;
    #1;
    chk("tx_first", {24'b0, tx_data}, 32'h41);
    idle();
    chk("tx_second", {24'b0, tx_data}, 32'h42);
    idle();
    chk("tx_drained", {31'b0, tx_valid}, 32'd0);

    // Overflowing the TX FIFO
    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) wr(8'h08, 32'(i + 16));
    rd(8'h00); chk("tx_full_stat", rdata, 32'd0);
    rd(8'h1C); chk("tx_ovf_status", rdata, 32'h0008_0001);
    wr(8'h1C, 32'h0);
    rd(8'h1C); chk("tx_ovf_cleared", rdata, 32'h0008_0000);
    tx_ready = 1'b1;
    repeat (9) idle();
    tx_ready = 1'b0;

    // RX byte, then pop of an empty FIFO
    rx_valid = 1'b1; rx_data = 8'h55;
    idle();
    rx_valid = 1'b0;
    rd(8'h0C); chk("rx_pop_55", rdata, 32'h55);
    rd(8'h04); chk("rx_empty_after", rdata, 32'd0);
    rd(8'h0C); chk("rx_pop_empty", rdata, 32'd0);
    rd(8'h1C); chk("rx_ovf_status", rdata, 32'h0000_0002);
    wr(8'h1C, 32'h0);

    // Stall freezes the pop and the instruction counter
    rx_valid = 1'b1; rx_data = 8'h66;
    idle();
    rx_valid = 1'b0;
    rd(8'h14); chk("ins_before_stall", rdata, 32'd0);
    stall = 1'b1; retire = 1'b1;
    repeat (3) rd(8'h0C);
    stall = 1'b0; retire = 1'b0;
    rd(8'h14); chk("ins_after_stall", rdata, 32'd0);
    rd(8'h04); chk("rx_kept_in_stall", rdata, 32'd1);
    rd(8'h0C); chk("rx_pop_66", rdata, 32'h66);

    // Counter wrap and clear racing an increment
    wr(8'h18, 32'h0);
    repeat (CMOD - 1) idle();
    rd(8'h10); chk("cyc_max", rdata, 32'(CMOD - 1));
    rd(8'h10); chk("cyc_wrap", rdata, 32'd0);
    retire = 1'b1;
    repeat (3) idle();
    wr(8'h18, 32'h0);
    retire = 1'b0;
    rd(8'h10); chk("cyc_cleared", rdata, 32'd0);
    rd(8'h14); chk("ins_cleared", rdata, 32'd0);

    // Randomized traffic, with a reset in the middle
    for (int i = 0; i < 2000; i++) begin
      rst_n    = !(i >= 1000 && i < 1002);
      stall    = ($urandom % 4) == 0;
      retire   = 1'($urandom);
      tx_ready = ($urandom % 3) != 0;
      rx_valid = ($urandom % 3) == 0;
      rx_data  = 8'($urandom);
      we       = ($urandom % 3) == 0;
      re       = ($urandom % 2) == 0;
      wdata    = $urandom;
      addr     = {(($urandom % 8) == 0) ? 4'($urandom) : 4'h8, 20'($urandom),
                  offs[$urandom_range(0, 9)]};
      @(posedge clk);
      #1;
    end
    we = 1'b0; re = 1'b0; stall = 1'b0; rx_valid = 1'b0; tx_ready = 1'b1; rst_n = 1'b1;
    repeat (12) idle();
    chk("tx_queue_drained", 32'(exp_tx.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/mmio_io_ctrl.md
# mmio_io_ctrl

Parametrised memory-mapped I/O controller for the MIPS150 pipeline, replacing the unbuffered UART decode path. It sits between the CPU data-memory port (load/store issued in stage Y, load data consumed in stage Z) and the UART byte handshake. It adds TX/RX FIFOs, a cycle counter, a retired-instruction counter and sticky overflow status. All side effects are frozen while the pipeline is stalled.

## Interface
Parameters:
- TX_DEPTH, 8, TX FIFO entries (power of two, ≥2)
- RX_DEPTH, 8, RX FIFO entries (power of two, ≥2)
- DATA_W, 8, UART character width (≤8)
- CNT_W, 32, counter width (≤32)

Ports:
- clk  in  1  single clock
- rst_n  in  1  synchronous, active-low reset
- stall  in  1  pipeline stall; blocks all state changes except the cycle counter
- addr  in  32  stage-Y byte address; selected when addr[31:28]==4'h8
- wdata  in  32  store data
- we  in  1  store strobe (stage Y)
- re  in  1  load strobe (stage Y)
- retire  in  1  one instruction retired this cycle
- rdata  out  32  load data, registered, valid in stage Z
- tx_data  out  DATA_W  byte to UART
- tx_valid  out  1  TX FIFO non-empty
- tx_ready  in  1  UART accepts byte
- rx_data  in  DATA_W  byte from UART
- rx_valid  in  1  UART has byte
- rx_ready  out  1  RX FIFO not full

## Operation
Address map (offset = addr[7:0], region selected):
- 0x00 R: bit0 = TX not full
- 0x04 R: bit0 = RX not empty
- 0x08 W: push wdata[DATA_W-1:0] into TX FIFO
- 0x0C R: pop RX FIFO; data zero-extended
- 0x10 R: cycle counter
- 0x14 R: instruction counter
- 0x18 W (any data): clear both counters
- 0x1C R: {tx_count[23:16], rx_count[15:8], 6'b0, rx_ovf[1], tx_ovf[0]}; W: clear both sticky flags
- Unmapped offsets: reads return 0; writes are ignored. Access outside the region has no effect.

Rules:
- An access takes effect only when re/we=1, stall=0 and the region is selected. If we and re are both set, we wins.
- TX push when full: byte dropped, tx_ovf set.
- RX pop when empty: returns 0, no pop, rx_ovf set.
- FIFOs have no bypass. Full/empty are evaluated on the registered state at the start of the cycle.
- Push and pop in the same cycle on a non-empty, non-full FIFO: count unchanged. On a full TX FIFO with tx_ready=1: the push is still rejected.
- UART transfer: pop TX when tx_valid&tx_ready; push RX when rx_valid&rx_ready. These are independent of stall.
- Cycle counter: +1 every cycle. Instruction counter: +1 when retire&!stall. Both wrap at 2^CNT_W to 0. A clear in the same cycle as an increment yields 0.
- Counters read as zero-extended to 32 bits.

## Timing
- rdata updates on the clock edge after the accepted re, and holds while stall=1 or when no read occurs.
- A read of 0x0C in cycle N returns the head entry at N. The pop is visible in 0x04 at N+1.
- Byte stored at cycle N: tx_valid=1 from N+1. A byte accepted from the UART at N is readable at N+1.
- Counter reads return the value before the current cycle's increment.
- Reset (rst_n=0 at an edge, including mid-transfer): FIFOs are emptied and the contents discarded. rdata=0, tx_valid=0, counters=0, flags=0. rx_ready=0 while rst_n=0 and 1 on the first cycle after.

## Structure
- Package io_pkg holds the region nibble 4'h8 and the offset constants for 0x00–0x1C.
- Sub-module sync_fifo(WIDTH, DEPTH) is instantiated twice. It provides push, pop, full, empty and count, with log2(DEPTH)+1-bit pointers.
- The top level contains only the decode, read mux, counters and flags.

## Test plan
- After reset: read 0x00→1, 0x04→0, 0x10 at cycle 5 after reset→5. tx_valid=0, rx_ready=1.
- Store 0x41,0x42 to 0x08 with tx_ready=0, then tx_ready=1 → tx_data is 0x41 then 0x42 on consecutive cycles, then tx_valid=0.
- Nine stores with TX_DEPTH=8 and tx_ready=0 → 0x00 reads 0, 0x1C reads tx_count=8 and tx_ovf=1. A write to 0x1C clears tx_ovf.
- Inject 0x55 on RX, then read 0x0C → rdata=0x55 in the next cycle, and 0x04 reads 0 after. A second read returns 0 and sets rx_ovf.
- Hold stall=1 with re on 0x0C and retire=1 for 3 cycles → no pop, instruction counter unchanged, cycle counter +3.
- Preload the cycle counter to 0xFFFFFFFF → wraps to 0. A write to 0x18 in the same cycle as retire → both counters read 0.
